// File: rtl/bus_timer_pkg.sv
// Shared bus_timer constants: register addresses and TCTL bit positions, also used by
// other bus devices and CPU test code.
package bus_timer_pkg;

   localparam logic [31:0] ADDR_CNT = 32'hF000_0020;
   localparam logic [31:0] ADDR_LIM = 32'hF000_0024;
   localparam logic [31:0] ADDR_CTL = 32'hF000_0120;

   localparam int CTL_RDY = 0;
   localparam int CTL_OVR = 2;
   localparam int CTL_IE  = 8;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_CNT,
      SEL_LIM,
      SEL_CTL
   } reg_sel_e;

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus port as seen by a memory-mapped device.
interface bus_timer_if #(
   parameter int DBITS = 32
);

   logic [DBITS-1:0] addrBus;
   logic [DBITS-1:0] wrData;
   logic             weBus;
   logic             reBus;
   logic [DBITS-1:0] rdData;

   modport master (
      output addrBus,
      output wrData,
      output weBus,
      output reBus,
      input  rdData
   );

   modport slave (
      input  addrBus,
      input  wrData,
      input  weBus,
      input  reBus,
      output rdData
   );

endinterface

// File: rtl/bus_timer_tick_prescaler.sv
// Divides the system clock into a one-cycle tick every CLK_DIV clocks; clear restarts
// the count so a freshly written timer gets a full first period.
module tick_prescaler #(
   parameter int unsigned CLK_DIV = 32'd100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer: TCNT/TLIM/TCTL registers on the CPU bus, counting
// prescaled ticks up to TLIM and raising a level interrupt while IE and RDY are set.
module bus_timer #(
   parameter int               DBITS    = 32,
   parameter int unsigned      CLK_DIV  = 32'd100000,
   parameter logic [DBITS-1:0] ADDR_CNT = bus_timer_pkg::ADDR_CNT,
   parameter logic [DBITS-1:0] ADDR_LIM = bus_timer_pkg::ADDR_LIM,
   parameter logic [DBITS-1:0] ADDR_CTL = bus_timer_pkg::ADDR_CTL,
   parameter logic [DBITS-1:0] INT_ID   = 'h1
) (
   input  logic             clk,
   input  logic             reset,
   bus_timer_if.slave       bus,
   output logic             inta,
   output logic [DBITS-1:0] idn
);

   import bus_timer_pkg::*;

   logic [DBITS-1:0] tcnt;
   logic [DBITS-1:0] tlim;
   logic             ie;
   logic             rdy;
   logic             ovr;

   reg_sel_e sel;
   logic     cnt_we;
   logic     lim_we;
   logic     ctl_we;
   logic     tick;
   logic     tick_eff;
   logic     wrap;

   always_comb begin
      sel = SEL_NONE;
      if (bus.addrBus == ADDR_CNT) begin
         sel = SEL_CNT;
      end else if (bus.addrBus == ADDR_LIM) begin
         sel = SEL_LIM;
      end else if (bus.addrBus == ADDR_CTL) begin
         sel = SEL_CTL;
      end
   end

   assign cnt_we = bus.weBus && (sel == SEL_CNT);
   assign lim_we = bus.weBus && (sel == SEL_LIM);
   assign ctl_we = bus.weBus && (sel == SEL_CTL);

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_we || lim_we),
      .tick  (tick)
   );

   // A store to TCNT or TLIM swallows a coincident tick.
   assign tick_eff = tick && !(cnt_we || lim_we);
   assign wrap     = tick_eff && (tlim != '0) && (tcnt == tlim - DBITS'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt <= '0;
         tlim <= '0;
         ie   <= 1'b0;
         rdy  <= 1'b0;
         ovr  <= 1'b0;
      end else begin
         if (lim_we) begin
            tlim <= bus.wrData;
            tcnt <= '0;
         end else if (cnt_we) begin
            tcnt <= bus.wrData;
         end else if (wrap) begin
            tcnt <= '0;
         end else if (tick_eff) begin
            tcnt <= tcnt + DBITS'(1);
         end
         if (ctl_we) begin
            ie <= bus.wrData[CTL_IE];
         end
         // Software can only clear the flags; a wrap in the same cycle still sets them.
         rdy <= (ctl_we ? (rdy && bus.wrData[CTL_RDY]) : rdy) || wrap;
         ovr <= (ctl_we ? (ovr && bus.wrData[CTL_OVR]) : ovr) || (wrap && rdy);
      end
   end

   always_comb begin
      bus.rdData = '0;
      if (bus.reBus) begin
         unique case (sel)
            SEL_CNT: bus.rdData = tcnt;
            SEL_LIM: bus.rdData = tlim;
            SEL_CTL: begin
               bus.rdData[CTL_IE]  = ie;
               bus.rdData[CTL_OVR] = ovr;
               bus.rdData[CTL_RDY] = rdy;
            end
            default: bus.rdData = '0;
         endcase
      end
   end

   assign inta = ie && rdy;
   assign idn  = INT_ID;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with CLK_DIV=4: a vector table for basic register access
// plus hand-timed sequences for wrap, overrun, collision and reset cases.
module tb_bus_timer;

   import bus_timer_pkg::*;

   logic        clk;
   logic        reset;
   logic        inta;
   logic [31:0] idn;
   int          checks;
   int          errors;

   bus_timer_if #(.DBITS(32)) bus ();

   bus_timer #(
      .DBITS   (32),
      .CLK_DIV (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .inta  (inta),
      .idn   (idn)
   );

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRd;
      logic        expInta;
   } vec_t;

   vec_t vecs[13];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the test completed");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      @(negedge clk);
      bus.weBus   = v.we;
      bus.reBus   = v.re;
      bus.addrBus = v.addr;
      bus.wrData  = v.wdata;
      #1;
      checkOutput($sformatf("vec%0d rdData", idx), bus.rdData, v.expRd);
      checkOutput($sformatf("vec%0d inta", idx), {31'b0, inta}, {31'b0, v.expInta});
      @(posedge clk);
      #1;
      bus.weBus = 1'b0;
      bus.reBus = 1'b0;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.weBus   = 1'b1;
      bus.addrBus = addr;
      bus.wrData  = data;
      @(posedge clk);
      #1;
      bus.weBus = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [31:0] addr,
                            input logic [31:0] expected);
      bus.reBus   = 1'b1;
      bus.addrBus = addr;
      #1;
      checkOutput(name, bus.rdData, expected);
      bus.reBus = 1'b0;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      bus.weBus   = 1'b0;
      bus.reBus   = 1'b0;
      bus.addrBus = '0;
      bus.wrData  = '0;

      vecs[0]  = '{1'b1, 1'b0, ADDR_LIM,      32'd1000,     32'h0,    1'b0};
      vecs[1]  = '{1'b0, 1'b1, ADDR_LIM,      32'h0,        32'd1000, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, ADDR_CNT,      32'h0,        32'h0,    1'b0};
      vecs[3]  = '{1'b1, 1'b1, ADDR_CNT,      32'h55,       32'h0,    1'b0};
      vecs[4]  = '{1'b0, 1'b1, ADDR_CNT,      32'h0,        32'h55,   1'b0};
      vecs[5]  = '{1'b1, 1'b0, ADDR_CTL,      32'h105,      32'h0,    1'b0};
      vecs[6]  = '{1'b0, 1'b1, ADDR_CTL,      32'h0,        32'h100,  1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'hF0000028,  32'h0,        32'h0,    1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'hF0000028,  32'hFFFFFFFF, 32'h0,    1'b0};
      vecs[9]  = '{1'b0, 1'b1, ADDR_LIM,      32'h0,        32'd1000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, ADDR_CNT,      32'h0,        32'h56,   1'b0};
      vecs[11] = '{1'b0, 1'b1, ADDR_CTL,      32'h0,        32'h100,  1'b0};
      vecs[12] = '{1'b0, 1'b0, ADDR_CNT,      32'h0,        32'h0,    1'b0};

      waitEdges(3);
      reset = 1'b0;
      checkOutput("reset inta", {31'b0, inta}, 32'h0);
      checkOutput("idn", idn, 32'h1);
      readCheck("reset TLIM", ADDR_LIM, 32'h0);
      readCheck("reset TCTL", ADDR_CTL, 32'h0);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(i, vecs[i]);
      end

      // First wrap lands exactly 12 clocks after the TLIM store.
      busWrite(ADDR_CTL, 32'h100);
      busWrite(ADDR_LIM, 32'd3);
      readCheck("wrap TCNT e0", ADDR_CNT, 32'd0);
      waitEdges(4);
      readCheck("wrap TCNT e4", ADDR_CNT, 32'd1);
      waitEdges(4);
      readCheck("wrap TCNT e8", ADDR_CNT, 32'd2);
      waitEdges(3);
      checkOutput("wrap inta e11", {31'b0, inta}, 32'h0);
      waitEdges(1);
      checkOutput("wrap inta e12", {31'b0, inta}, 32'h1);
      readCheck("wrap TCNT e12", ADDR_CNT, 32'd0);
      readCheck("wrap TCTL e12", ADDR_CTL, 32'h101);

      waitEdges(12);
      readCheck("overrun TCTL", ADDR_CTL, 32'h105);
      checkOutput("overrun inta", {31'b0, inta}, 32'h1);
      busWrite(ADDR_CTL, 32'h100);
      readCheck("clear TCTL", ADDR_CTL, 32'h100);
      checkOutput("clear inta", {31'b0, inta}, 32'h0);

      // TCTL clear landing on a wrap edge: the set wins and OVR sees the old RDY.
      busWrite(ADDR_LIM, 32'd3);
      waitEdges(12);
      readCheck("collide pre TCTL", ADDR_CTL, 32'h101);
      waitEdges(11);
      busWrite(ADDR_CTL, 32'h100);
      readCheck("collide TCTL", ADDR_CTL, 32'h105);
      readCheck("collide TCNT", ADDR_CNT, 32'd0);
      waitEdges(3);
      busWrite(ADDR_CNT, 32'd1);
      readCheck("tick-write TCNT", ADDR_CNT, 32'd1);
      waitEdges(3);
      readCheck("tick-write TCNT +3", ADDR_CNT, 32'd1);
      waitEdges(1);
      readCheck("tick-write TCNT +4", ADDR_CNT, 32'd2);

      busWrite(ADDR_CTL, 32'h0);
      busWrite(ADDR_LIM, 32'h0);
      busWrite(ADDR_CNT, 32'hFFFFFFFF);
      readCheck("freerun TCNT max", ADDR_CNT, 32'hFFFFFFFF);
      waitEdges(4);
      readCheck("freerun TCNT wrap", ADDR_CNT, 32'h0);
      readCheck("freerun TCTL", ADDR_CTL, 32'h0);
      waitEdges(4);
      readCheck("freerun TCNT next", ADDR_CNT, 32'h1);

      // Reset mid-count with a store pending in the same cycle.
      busWrite(ADDR_LIM, 32'd3);
      busWrite(ADDR_CTL, 32'h100);
      waitEdges(6);
      @(negedge clk);
      reset       = 1'b1;
      bus.weBus   = 1'b1;
      bus.addrBus = ADDR_LIM;
      bus.wrData  = 32'd5;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset       = 1'b0;
      bus.weBus   = 1'b0;
      bus.reBus   = 1'b0;
      bus.addrBus = ADDR_CTL;
      #1;
      checkOutput("post-reset rdData idle", bus.rdData, 32'h0);
      checkOutput("post-reset inta", {31'b0, inta}, 32'h0);
      readCheck("post-reset TCNT", ADDR_CNT, 32'h0);
      readCheck("post-reset TLIM", ADDR_LIM, 32'h0);
      readCheck("post-reset TCTL", ADDR_CTL, 32'h0);
      waitEdges(4);
      readCheck("post-reset TCNT tick", ADDR_CNT, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
